param_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one width-adapting pass-through register stage between `NREQ` requesters. Each requester offers an `N`-bit word with valid/ready. The arbiter grants one requester per accepted transfer, adapts the word to `M` bits, and presents it on a single registered output port with valid/ready. It sits in front of any consumer that needs several parameterised-width sources funnelled onto one `M`-bit datapath.

---
 rtl/param_rr_pkg.sv | 29 ++
 rtl/param_rr_arbiter_rr_pick.sv | 43 ++++
 rtl/param_rr_arbiter.sv | 92 +++++++++
 tb/tb_param_rr_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/param_rr_pkg.sv
// Shared types and helpers for the round-robin width-adapting arbiter.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package param_rr_pkg;

    // Output register occupancy.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Width adaptation carried on a 32-bit scratch word. Keeping only the
    // low min(n, m) bits gives zero-extension when m > n, truncation to the
    // low bits when m < n, and a plain pass-through when m == n.
    function automatic logic [31:0] adapt(input logic [31:0] word, input int n, input int m);
        int          keep;
        logic [31:0] mask;
        keep = (m < n) ? m : n;
        mask = (keep >= 32) ? 32'hFFFF_FFFF : ((32'd1 << keep) - 32'd1);
        return word & mask;
    endfunction

    // Increment that wraps from nreq-1 back to 0. This drives the
    // round-robin pointer.
    function automatic logic [4:0] wrap_inc(input logic [4:0] v, input int nreq);
        return (int'(v) >= nreq - 1) ? 5'd0 : v + 5'd1;
    endfunction

endpackage

// File: rtl/param_rr_arbiter_rr_pick.sv
// Round-robin pick: the first valid requester at or after ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller gates the pick with its own accept window.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int SW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [SW-1:0]   ptr,
    output logic [NREQ-1:0] grant_oh,
    output logic [SW-1:0]   grant_idx,
    output logic            any
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int                pos;
    int                idx;

    // Rotate the request vector so ptr lands at bit 0. Pick the lowest set
    // bit, then add ptr back to get the requester index.
    always_comb begin
        dbl = {req_valid, req_valid} >> ptr;
        rot = dbl[NREQ-1:0];
        any = |req_valid;
        pos = 0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                pos = j;
            end
        end
        idx = pos + int'(ptr);
        if (idx >= NREQ) begin
            idx = idx - NREQ;
        end
        grant_idx = SW'(idx);
        grant_oh  = '0;
        if (any) begin
            grant_oh[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/param_rr_arbiter.sv
// Round-robin funnel of NREQ N-bit valid/ready sources onto one registered M-bit output.
// Latency: 1 cycle from grant edge to out_*; throughput one word per cycle.
// Backpressure: out_ready=0 while FULL holds the output and forces req_ready to zero.
module param_rr_arbiter
    import param_rr_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int N    = 3,
    parameter int M    = 3,
    parameter int SW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    output logic [M-1:0]      out_data,
    output logic [SW-1:0]     out_src,
    input  logic              out_ready
);

    state_t          state_q, state_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [M-1:0]    out_data_q, out_data_d;
    logic [SW-1:0]   out_src_q, out_src_d;

    logic [NREQ-1:0] grant_oh;
    logic [SW-1:0]   grant_idx;
    logic            any;
    logic            accept;
    logic            grant;
    logic [N-1:0]    pick_word;

    rr_pick #(
        .NREQ (NREQ),
        .SW   (SW)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any       (any)
    );

    // Take a new word when the register is empty or is being drained this
    // cycle. Grants stay off while reset is held.
    always_comb begin
        accept    = (state_q == EMPTY) || out_ready;
        grant     = accept && any && !rst;
        req_ready = grant ? grant_oh : '0;
        pick_word = req_data[grant_idx*N +: N];
    end

    // Next-state logic: load on a grant (this also covers pop and refill in
    // the same cycle), go empty on a pop with no refill, otherwise hold.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        if (grant) begin
            state_d    = FULL;
            out_data_d = M'(adapt(32'(pick_word), N, M));
            out_src_d  = grant_idx;
            ptr_d      = SW'(wrap_inc(5'(grant_idx), NREQ));
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    // State, pointer and output register. Reset drops any word held in the
    // register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            ptr_q      <= '0;
            out_data_q <= '0;
            out_src_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_param_rr_arbiter.sv
module tb_param_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // Main instance: NREQ=4, N=M=3.
    logic [3:0]  req_valid;
    logic [11:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [2:0]  out_data;
    logic [1:0]  out_src;
    logic        out_ready;

    // Narrowing instance: N=5, M=3.
    logic [3:0]  a_valid, a_ready;
    logic [19:0] a_data;
    logic        a_ov;
    logic [2:0]  a_od;
    logic [1:0]  a_os;

    // Widening instance: N=3, M=5.
    logic [3:0]  b_valid, b_ready;
    logic [11:0] b_data;
    logic        b_ov;
    logic [4:0]  b_od;
    logic [1:0]  b_os;

    logic        ab_out_ready;

    param_rr_arbiter #(.NREQ(4), .N(3), .M(3)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .out_ready(out_ready)
    );

    param_rr_arbiter #(.NREQ(4), .N(5), .M(3)) dut_n5m3 (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_data(a_data),
        .req_ready(a_ready), .out_valid(a_ov), .out_data(a_od),
        .out_src(a_os), .out_ready(ab_out_ready)
    );

    param_rr_arbiter #(.NREQ(4), .N(3), .M(5)) dut_n3m5 (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_data(b_data),
        .req_ready(b_ready), .out_valid(b_ov), .out_data(b_od),
        .out_src(b_os), .out_ready(ab_out_ready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: round-robin pointer, occupancy, and a scoreboard of
    // granted words as {src, data}.
    int         mptr;
    bit         mfull;
    logic [4:0] sb[$];

    // One clock cycle. Inputs are driven just after a falling edge. The
    // expected grant is checked, a pop is scored against the queue, and the
    // occupancy is checked after the next rising edge.
    task automatic cycle(input logic [3:0] v, input logic [11:0] d, input logic r);
        logic [3:0]  exp_rdy;
        logic [4:0]  ent;
        logic [11:0] dd;
        int          win;
        req_valid = v;
        req_data  = d;
        out_ready = r;
        dd        = d;
        #1;
        exp_rdy = 4'b0000;
        win     = -1;
        if (!mfull || r) begin
            for (int k = 0; k < 4; k++) begin
                if (win < 0 && v[(mptr + k) % 4]) win = (mptr + k) % 4;
            end
        end
        if (win >= 0) exp_rdy[win] = 1'b1;
        check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (mfull && r) begin
            check_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                ent = sb.pop_front();
                check_eq("out_src", 32'(out_src), 32'(ent[4:3]));
                check_eq("out_data", 32'(out_data), 32'(ent[2:0]));
            end
        end
        if (win >= 0) begin
            sb.push_back({2'(win), dd[win*3 +: 3]});
            mptr  = (win + 1) % 4;
            mfull = 1'b1;
        end else if (mfull && r) begin
            mfull = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("out_valid", 32'(out_valid), 32'(mfull));
    endtask

    logic [11:0] rr_d, bp_d, rs_d;

    initial begin
        rst          = 1'b1;
        req_valid    = 4'hF;
        req_data     = '0;
        out_ready    = 1'b1;
        a_valid      = '0;
        a_data       = '0;
        b_valid      = '0;
        b_data       = '0;
        ab_out_ready = 1'b1;
        mptr         = 0;
        mfull        = 1'b0;
        rr_d = {3'd4, 3'd3, 3'd2, 3'd1};
        bp_d = {3'd7, 3'd6, 3'd2, 3'd1};
        rs_d = {3'd0, 3'd0, 3'd5, 3'd0};

        // Reset values. No grants while reset is held.
        @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_out_src", 32'(out_src), 32'd0);
        rst       = 1'b0;
        req_valid = 4'h0;

        // Width adaptation on the narrowing and widening instances.
        a_valid = 4'b0001;
        a_data  = 20'b10110;
        b_valid = 4'b0001;
        b_data  = 12'b101;
        @(posedge clk);
        @(negedge clk);
        check_eq("w_n5m3_data", 32'(a_od), 32'(3'b110));
        check_eq("w_n5m3_valid", 32'(a_ov), 32'd1);
        check_eq("w_n3m5_data", 32'(b_od), 32'(5'b00101));
        check_eq("w_n3m5_valid", 32'(b_ov), 32'd1);
        a_valid = '0;
        b_valid = '0;

        // Round-robin with every source requesting: one word per cycle.
        for (int i = 0; i < 9; i++) cycle(4'hF, rr_d, 1'b1);
        cycle(4'h0, rr_d, 1'b1);

        // Backpressure: grant source 2, stall 5 cycles, then release.
        cycle(4'b0100, bp_d, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(4'hF, bp_d, 1'b0);
            check_eq("bp_hold_data", 32'(out_data), 32'd6);
            check_eq("bp_hold_src", 32'(out_src), 32'd2);
        end
        cycle(4'hF, bp_d, 1'b1);
        check_eq("bp_next_src", 32'(out_src), 32'd3);

        // Pointer wrap: source 3 alone, then sources 0 and 1.
        cycle(4'b1000, rr_d, 1'b1);
        check_eq("wrap_src3", 32'(out_src), 32'd3);
        cycle(4'b0011, rr_d, 1'b1);
        check_eq("wrap_src0", 32'(out_src), 32'd0);
        cycle(4'b0011, rr_d, 1'b1);
        check_eq("wrap_src1", 32'(out_src), 32'd1);

        // Drain, idle, then confirm the pointer did not move while idle.
        cycle(4'h0, rr_d, 1'b1);
        cycle(4'h0, rr_d, 1'b1);
        cycle(4'hF, rr_d, 1'b1);
        check_eq("idle_ptr_src", 32'(out_src), 32'd2);
        cycle(4'h0, rr_d, 1'b1);

        // Asynchronous reset while holding the word 5.
        cycle(4'b0010, rs_d, 1'b0);
        check_eq("pre_rst_data", 32'(out_data), 32'd5);
        req_valid = 4'hF;
        out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_out_data", 32'(out_data), 32'd0);
        check_eq("arst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("arst_req_ready_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        mptr  = 0;
        mfull = 1'b0;
        sb.delete();
        cycle(4'hF, rr_d, 1'b1);
        check_eq("post_rst_src", 32'(out_src), 32'd0);
        cycle(4'h0, rr_d, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
